// File: rtl/vga_pkg.sv
// Shared raster definitions for the 800x600@72 display path: default timing,
// derived coordinate limits and the signed beam-coordinate type.
package vga_pkg;

  localparam int DEF_HACTIVE    = 800;
  localparam int DEF_HFP        = 56;
  localparam int DEF_HSYNC      = 120;
  localparam int DEF_HBP        = 64;
  localparam int DEF_VACTIVE    = 600;
  localparam int DEF_VFP        = 37;
  localparam int DEF_VSYNC      = 6;
  localparam int DEF_VBP        = 23;
  localparam bit DEF_SYNC_POL   = 1'b1;
  localparam int DEF_PIPE_DELAY = 1;

  // Origin is the first active pixel, so everything before it is negative.
  localparam int XMIN = -(DEF_HSYNC + DEF_HBP);
  localparam int XMAX = DEF_HACTIVE + DEF_HFP - 1;
  localparam int YMIN = -(DEF_VSYNC + DEF_VBP);
  localparam int YMAX = DEF_VACTIVE + DEF_VFP - 1;

  localparam int COORD_MIN = -1024;
  localparam int COORD_MAX = 1023;

  typedef logic signed [10:0] coord_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
    logic line_start;
    logic frame_start;
  } flags_t;

  function automatic coord_t to_coord(input int v);
    return coord_t'(v);
  endfunction

endpackage

// File: rtl/vga_timing_sync_delay.sv
// Synchronous-reset shift register that delays the raster flags so they line
// up with the registered RGB of the colour stages.
module sync_delay #(
  parameter int               DEPTH     = 1,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      // NOTE: every stage is reset, not just the output one; otherwise stale
      // flags from before reset would leak out for DEPTH-1 cycles.
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing.sv
// Free-running raster generator: signed beam coordinates plus sync/blank/pulse
// flags delayed to match the colour-stage latency.
module vga_timing
  import vga_pkg::*;
#(
  parameter int HACTIVE    = DEF_HACTIVE,
  parameter int HFP        = DEF_HFP,
  parameter int HSYNC      = DEF_HSYNC,
  parameter int HBP        = DEF_HBP,
  parameter int VACTIVE    = DEF_VACTIVE,
  parameter int VFP        = DEF_VFP,
  parameter int VSYNC      = DEF_VSYNC,
  parameter int VBP        = DEF_VBP,
  parameter bit SYNC_POL   = DEF_SYNC_POL,
  parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
  input  logic               clk,
  input  logic               reset,
  output logic signed [10:0] spotX,
  output logic signed [10:0] spotY,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic               line_start,
  output logic               frame_start
);

  localparam int XMIN_I = -(HSYNC + HBP);
  localparam int XMAX_I = HACTIVE + HFP - 1;
  localparam int YMIN_I = -(VSYNC + VBP);
  localparam int YMAX_I = VACTIVE + VFP - 1;

  if (XMIN_I < COORD_MIN || XMAX_I > COORD_MAX) begin : g_bad_x
    $error("vga_timing: horizontal timing does not fit an 11-bit signed coordinate");
  end
  if (YMIN_I < COORD_MIN || YMAX_I > COORD_MAX) begin : g_bad_y
    $error("vga_timing: vertical timing does not fit an 11-bit signed coordinate");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_delay
    $error("vga_timing: PIPE_DELAY must be 0..4");
  end

  localparam coord_t X_LO   = to_coord(XMIN_I);
  localparam coord_t X_HI   = to_coord(XMAX_I);
  localparam coord_t Y_LO   = to_coord(YMIN_I);
  localparam coord_t Y_HI   = to_coord(YMAX_I);
  localparam coord_t HS_END = to_coord(-HBP);
  localparam coord_t VS_END = to_coord(-VBP);
  localparam coord_t X_ACT  = to_coord(HACTIVE);
  localparam coord_t Y_ACT  = to_coord(VACTIVE);
  localparam coord_t ZERO   = '0;

  localparam flags_t FLAGS_IDLE = '{
    hsync:       ~SYNC_POL,
    vsync:       ~SYNC_POL,
    blank:       1'b1,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  logic   hs_raw, vs_raw, act_raw;
  flags_t raw, dly;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so spotY sees the pre-edge spotX in the same cycle.
    if (reset) begin
      spotX <= X_LO;
      spotY <= Y_LO;
    end else if (spotX == X_HI) begin
      spotX <= X_LO;
      spotY <= (spotY == Y_HI) ? Y_LO : spotY + 11'sd1;
    end else begin
      spotX <= spotX + 11'sd1;
    end
  end

  // All comparisons are between signed 11-bit operands.
  always_comb begin
    // NOTE: raw takes a full default first so no field can become a latch.
    raw     = FLAGS_IDLE;
    hs_raw  = (spotX < HS_END);
    vs_raw  = (spotY < VS_END);
    act_raw = (spotX >= ZERO) && (spotX < X_ACT) && (spotY >= ZERO) && (spotY < Y_ACT);

    raw.hsync       = hs_raw ~^ SYNC_POL;
    raw.vsync       = vs_raw ~^ SYNC_POL;
    raw.blank       = ~act_raw;
    raw.line_start  = (spotX == ZERO);
    raw.frame_start = (spotX == ZERO) && (spotY == ZERO);
  end

  sync_delay #(
    .DEPTH     (PIPE_DELAY),
    .WIDTH     ($bits(flags_t)),
    .RESET_VAL (FLAGS_IDLE)
  ) u_flag_delay (
    .clk   (clk),
    .reset (reset),
    .d     (raw),
    .q     (dly)
  );

  assign hsync       = dly.hsync;
  assign vsync       = dly.vsync;
  assign blank       = dly.blank;
  assign line_start  = dly.line_start;
  assign frame_start = dly.frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench: hand-computed expectations are queued per cycle and popped
// by a monitor; a reduced-timing build covers whole frames and delay variants.
module tb_vga_timing;

  typedef enum {DEV_DEF, DEV_S1, DEV_S0} dev_e;
  typedef enum {SX, SY, HS, VS, BL, LS, FS} sig_e;

  typedef struct {
    int    phase;
    int    cyc;
    dev_e  dev;
    sig_e  sig;
    int    exp;
    string name;
  } exp_t;

  logic clk;
  logic reset;
  int   k;
  int   phase;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  // Default 800x600 build, PIPE_DELAY=1, positive sync.
  logic signed [10:0] d_x, d_y;
  logic d_hs, d_vs, d_bl, d_ls, d_fs;
  // Reduced timing (line 15 cycles, frame 8 lines): XMIN=-5 XMAX=9 YMIN=-3 YMAX=4.
  logic signed [10:0] s1_x, s1_y, s0_x, s0_y, s3_x, s3_y;
  logic s1_hs, s1_vs, s1_bl, s1_ls, s1_fs;
  logic s0_hs, s0_vs, s0_bl, s0_ls, s0_fs;
  logic s3_hs, s3_vs, s3_bl, s3_ls, s3_fs;

  vga_timing dut (
    .clk(clk), .reset(reset), .spotX(d_x), .spotY(d_y), .hsync(d_hs), .vsync(d_vs),
    .blank(d_bl), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing #(.HACTIVE(8), .HFP(2), .HSYNC(3), .HBP(2), .VACTIVE(4), .VFP(1), .VSYNC(2),
               .VBP(1), .SYNC_POL(1'b0), .PIPE_DELAY(1)) u_s1 (
    .clk(clk), .reset(reset), .spotX(s1_x), .spotY(s1_y), .hsync(s1_hs), .vsync(s1_vs),
    .blank(s1_bl), .line_start(s1_ls), .frame_start(s1_fs)
  );

  vga_timing #(.HACTIVE(8), .HFP(2), .HSYNC(3), .HBP(2), .VACTIVE(4), .VFP(1), .VSYNC(2),
               .VBP(1), .SYNC_POL(1'b1), .PIPE_DELAY(0)) u_s0 (
    .clk(clk), .reset(reset), .spotX(s0_x), .spotY(s0_y), .hsync(s0_hs), .vsync(s0_vs),
    .blank(s0_bl), .line_start(s0_ls), .frame_start(s0_fs)
  );

  vga_timing #(.HACTIVE(8), .HFP(2), .HSYNC(3), .HBP(2), .VACTIVE(4), .VFP(1), .VSYNC(2),
               .VBP(1), .SYNC_POL(1'b1), .PIPE_DELAY(3)) u_s3 (
    .clk(clk), .reset(reset), .spotX(s3_x), .spotY(s3_y), .hsync(s3_hs), .vsync(s3_vs),
    .blank(s3_bl), .line_start(s3_ls), .frame_start(s3_fs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index: 0 while reset is sampled, then 1 on the first edge after release.
  always @(posedge clk) k <= reset ? 0 : k + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (phase %0d cycle %0d)", name, act, exp, phase, k);
    end
  endtask

  task automatic push(input int ph, input int c, input dev_e d, input sig_e s, input int v,
                      input string n);
    exp_t e;
    e.phase = ph; e.cyc = c; e.dev = d; e.sig = s; e.exp = v; e.name = n;
    sb.push_back(e);
  endtask

  function automatic int obs(input dev_e d, input sig_e s);
    logic signed [10:0] x, y;
    logic [4:0] f;
    case (d)
      DEV_DEF: begin x = d_x;  y = d_y;  f = {d_hs, d_vs, d_bl, d_ls, d_fs}; end
      DEV_S1:  begin x = s1_x; y = s1_y; f = {s1_hs, s1_vs, s1_bl, s1_ls, s1_fs}; end
      default: begin x = s0_x; y = s0_y; f = {s0_hs, s0_vs, s0_bl, s0_ls, s0_fs}; end
    endcase
    case (s)
      SX:      return int'(x);
      SY:      return int'(y);
      HS:      return int'(f[4]);
      VS:      return int'(f[3]);
      BL:      return int'(f[2]);
      LS:      return int'(f[1]);
      default: return int'(f[0]);
    endcase
  endfunction

  // Monitor state
  logic [4:0] s0_hist [512];
  int fs_n, t1, t2, ls_cnt, vs_cnt, bl_cnt, hs_run, hs_max, early_fs;

  always @(negedge clk) begin
    exp_t e;
    if (phase == 1 && k < 512) s0_hist[k] = {s0_hs, s0_vs, s0_bl, s0_ls, s0_fs};
    if (phase == 1 && k >= 4 && k <= 400) begin
      check("pipe3_flags", int'({s3_hs, s3_vs, s3_bl, s3_ls, s3_fs}), int'(s0_hist[k-3]));
      check("pipe3_spotX", int'(s3_x), int'(s0_x));
      check("pipe3_spotY", int'(s3_y), int'(s0_y));
    end
    while (sb.size() != 0 && sb[0].phase == phase && sb[0].cyc == k) begin
      e = sb.pop_front();
      check(e.name, obs(e.dev, e.sig), e.exp);
    end
    if (phase == 1 && !reset) begin
      if (s1_fs) begin
        fs_n++;
        if (fs_n == 1) t1 = k;
        else if (fs_n == 2) t2 = k;
      end
      if (fs_n == 1) begin
        if (s1_ls) ls_cnt++;
        if (!s1_vs) vs_cnt++;
        if (!s1_bl) bl_cnt++;
        if (!s1_hs) begin
          hs_run++;
          if (hs_run > hs_max) hs_max = hs_run;
        end else begin
          hs_run = 0;
        end
      end
    end
    if (phase == 2 && !reset && k >= 1 && k <= 50 && s1_fs) early_fs++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    n_checks = 0; n_errors = 0;
    fs_n = 0; t1 = 0; t2 = 0; ls_cnt = 0; vs_cnt = 0; bl_cnt = 0;
    hs_run = 0; hs_max = 0; early_fs = 0;
    reset = 1'b1;
    phase = 1;

    // Phase 1 expectations, ascending cycle order.
    push(1, 0, DEV_DEF, SX, -184, "rst_spotX");
    push(1, 0, DEV_DEF, SY, -29,  "rst_spotY");
    push(1, 0, DEV_DEF, HS, 0,    "rst_hsync");
    push(1, 0, DEV_DEF, VS, 0,    "rst_vsync");
    push(1, 0, DEV_DEF, BL, 1,    "rst_blank");
    push(1, 0, DEV_DEF, LS, 0,    "rst_line_start");
    push(1, 0, DEV_DEF, FS, 0,    "rst_frame_start");
    push(1, 0, DEV_S1,  HS, 1,    "s1_rst_hsync_neg_pol");
    push(1, 0, DEV_S1,  VS, 1,    "s1_rst_vsync_neg_pol");
    push(1, 0, DEV_S0,  HS, 1,    "s0_rst_hsync_direct");
    push(1, 1, DEV_DEF, SX, -183, "first_spotX");
    push(1, 1, DEV_DEF, HS, 1,    "first_hsync");
    push(1, 1, DEV_DEF, VS, 1,    "first_vsync");
    push(1, 1, DEV_S1,  HS, 0,    "s1_first_hsync");
    push(1, 5, DEV_S0,  SX, 0,    "s0_origin_spotX");
    push(1, 5, DEV_S0,  LS, 1,    "s0_line_start_undelayed");
    push(1, 5, DEV_S0,  BL, 1,    "s0_blank_in_vblank");
    push(1, 120, DEV_DEF, HS, 1,  "hsync_last_cycle");
    push(1, 121, DEV_DEF, HS, 0,  "hsync_end");
    push(1, 184, DEV_DEF, SX, 0,  "line_origin_spotX");
    push(1, 184, DEV_DEF, LS, 0,  "line_start_before");
    push(1, 185, DEV_DEF, LS, 1,  "line_start_pulse");
    push(1, 185, DEV_DEF, FS, 0,  "no_frame_start_blank_line");
    push(1, 186, DEV_DEF, LS, 0,  "line_start_one_cycle");
    push(1, 1039, DEV_DEF, SX, 855, "spotX_max");
    push(1, 1039, DEV_DEF, SY, -29, "spotY_before_wrap");
    push(1, 1040, DEV_DEF, SX, -184, "spotX_wrap");
    push(1, 1040, DEV_DEF, SY, -28, "spotY_step");
    push(1, 30344, DEV_DEF, SX, 0,  "origin_spotX");
    push(1, 30344, DEV_DEF, SY, 0,  "origin_spotY");
    push(1, 30344, DEV_DEF, BL, 1,  "blank_before_active");
    push(1, 30344, DEV_DEF, FS, 0,  "frame_start_before");
    push(1, 30345, DEV_DEF, BL, 0,  "blank_first_active");
    push(1, 30345, DEV_DEF, FS, 1,  "frame_start_pulse");
    push(1, 30345, DEV_DEF, LS, 1,  "line_start_with_frame");
    push(1, 30346, DEV_DEF, FS, 0,  "frame_start_one_cycle");

    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (30400) @(negedge clk);

    // Frame-level measurements on the reduced build (period 15*8 = 120).
    check("s1_frame_pulses_seen", int'(fs_n >= 2), 1);
    check("s1_frame_period", t2 - t1, 120);
    check("s1_line_starts_per_frame", ls_cnt, 8);
    check("s1_vsync_active_cycles", vs_cnt, 30);
    check("s1_active_cycles", bl_cnt, 32);
    check("s1_hsync_width", hs_max, 3);

    // Mid-frame reset on the reduced build at spotX=4, spotY=2.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (s1_x == 11'sd4 && s1_y == 11'sd2) found = 1'b1;
    end
    check("midframe_point_reached", int'(found), 1);
    if (found) begin
      push(2, 0, DEV_S1, SX, -5, "mid_rst_spotX");
      push(2, 0, DEV_S1, SY, -3, "mid_rst_spotY");
      push(2, 0, DEV_S1, HS, 1,  "mid_rst_hsync");
      push(2, 0, DEV_S1, VS, 1,  "mid_rst_vsync");
      push(2, 0, DEV_S1, BL, 1,  "mid_rst_blank");
      push(2, 0, DEV_S1, LS, 0,  "mid_rst_line_start");
      push(2, 0, DEV_S1, FS, 0,  "mid_rst_frame_start");
      push(2, 0, DEV_DEF, SX, -184, "mid_rst_def_spotX");
      push(2, 0, DEV_DEF, SY, -29,  "mid_rst_def_spotY");
      push(2, 50, DEV_S1, SX, 0, "preroll_origin_spotX");
      push(2, 50, DEV_S1, SY, 0, "preroll_origin_spotY");
      push(2, 50, DEV_S1, FS, 0, "preroll_no_frame_start");
      push(2, 51, DEV_S1, FS, 1, "preroll_frame_start");
      push(2, 51, DEV_S1, BL, 0, "preroll_first_active");
      phase = 2;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (60) @(negedge clk);
      check("preroll_early_frame_starts", early_fs, 0);
    end

    check("scoreboard_unconsumed", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
